// File: rtl/alu_issue_ctrl.sv
// Issue stage driving ALUCon/DataA/DataB to the ALU and capturing Result with valid/ready.
// Define ALU_ISSUE_BACK2BACK_EN to accept a new instruction on the cycle a result drains.
module alu_issue_ctrl #(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [3:0]  ALUCon,
  output logic [31:0] DataA,
  output logic [31:0] DataB,
  input  logic [31:0] alu_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_err
);

  localparam int unsigned MaxLat = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CntW   = $clog2(MaxLat + 1);

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q;
  logic [3:0]        alucon_q;
  logic [31:0]       data_a_q, data_b_q, result_q;
  logic              err_q;

  logic              accept;
  logic              dec_legal, dec_div, div_zero;
  logic [3:0]        dec_con;
  logic [31:0]       dec_a, dec_b;
  logic [CntW-1:0]   dec_lat;

  assign accept   = in_valid & in_ready;
  assign div_zero = dec_div & (rt_data == 32'd0);

  // Instruction decode; dec_lat is the number of cycles the operands are held.
  always_comb begin
    dec_legal = 1'b1;
    dec_div   = 1'b0;
    dec_con   = 4'b0000;
    dec_a     = rs_data;
    dec_b     = rt_data;
    dec_lat   = CntW'(1);
    if (opcode == 6'h00) begin
      case (funct)
        6'h24:        dec_con = 4'b0000;
        6'h25:        dec_con = 4'b0001;
        6'h20, 6'h21: dec_con = 4'b0010;
        6'h18: begin
          dec_con = 4'b0011;
          dec_lat = CntW'(MUL_LAT);
        end
        6'h27:        dec_con = 4'b0100;
        6'h1A: begin
          dec_con = 4'b0101;
          dec_lat = CntW'(DIV_LAT);
          dec_div = 1'b1;
        end
        6'h22, 6'h23: dec_con = 4'b0110;
        6'h2A:        dec_con = 4'b0111;
        6'h00: begin
          dec_con = 4'b1000;
          dec_a   = rt_data;
          dec_b   = {27'b0, shamt};
        end
        default:      dec_legal = 1'b0;
      endcase
    end else begin
      case (opcode)
        6'h08, 6'h09, 6'h23, 6'h2B: begin
          dec_con = 4'b0010;
          dec_b   = {{16{imm[15]}}, imm};
        end
        6'h0A: begin
          dec_con = 4'b0111;
          dec_b   = {{16{imm[15]}}, imm};
        end
        6'h0C: begin
          dec_con = 4'b0000;
          dec_b   = {16'b0, imm};
        end
        6'h0D: begin
          dec_con = 4'b0001;
          dec_b   = {16'b0, imm};
        end
        default: dec_legal = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  state_d = StIdle;
      StExec:  if (cnt_q == CntW'(1)) state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Accept can only happen in Idle, or in Done while draining (back-to-back build).
    if (accept) state_d = (dec_legal && !div_zero) ? StExec : StDone;
  end

  always_comb begin
    out_valid = (state_q == StDone);
`ifdef ALU_ISSUE_BACK2BACK_EN
    in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
`else
    in_ready  = (state_q == StIdle);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      alucon_q <= 4'b0000;
      data_a_q <= 32'd0;
      data_b_q <= 32'd0;
      result_q <= 32'd0;
      err_q    <= 1'b0;
    end else if (accept) begin
      // Illegal ops leave the ALU-facing registers untouched.
      if (dec_legal) begin
        alucon_q <= dec_con;
        data_a_q <= dec_a;
        data_b_q <= dec_b;
        cnt_q    <= dec_lat;
      end
      if (!dec_legal) begin
        result_q <= 32'd0;
        err_q    <= 1'b1;
      end else if (div_zero) begin
        result_q <= 32'hFFFF_FFFF;
        err_q    <= 1'b1;
      end
    end else if (state_q == StExec) begin
      if (cnt_q == CntW'(1)) begin
        result_q <= alu_result;
        err_q    <= 1'b0;
      end else begin
        cnt_q <= cnt_q - CntW'(1);
      end
    end
  end

  assign ALUCon     = alucon_q;
  assign DataA      = data_a_q;
  assign DataB      = data_b_q;
  assign out_result = result_q;
  assign out_err    = err_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: behavioural ALU plus an instruction-level reference model.
module tb_alu_issue_ctrl;

  localparam int unsigned MUL_LAT = 4;
  localparam int unsigned DIV_LAT = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [15:0] imm;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [3:0]  ALUCon;
  logic [31:0] DataA;
  logic [31:0] DataB;
  logic [31:0] alu_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_err;

  int checks   = 0;
  int failures = 0;

  // Operand values the ALU-facing outputs must currently hold.
  logic [3:0]  m_con;
  logic [31:0] m_a, m_b;

  alu_issue_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct(funct), .shamt(shamt), .imm(imm),
    .rs_data(rs_data), .rt_data(rt_data), .ALUCon(ALUCon), .DataA(DataA), .DataB(DataB),
    .alu_result(alu_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_err(out_err)
  );

  always #5 clk = ~clk;

  // Behavioural ALU on the far side of the interface.
  always_comb begin
    case (ALUCon)
      4'b0000: alu_result = DataA & DataB;
      4'b0001: alu_result = DataA | DataB;
      4'b0010: alu_result = DataA + DataB;
      4'b0011: alu_result = DataA * DataB;
      4'b0100: alu_result = ~(DataA | DataB);
      4'b0101: alu_result = (DataB == 0) ? 32'hDEAD_BEEF : 32'($signed(DataA) / $signed(DataB));
      4'b0110: alu_result = DataA - DataB;
      4'b0111: alu_result = {31'b0, $signed(DataA) < $signed(DataB)};
      4'b1000: alu_result = DataA << DataB[4:0];
      default: alu_result = 32'h0;
    endcase
  end

  // Instruction-level model: what the instruction should produce and when.
  function automatic void ref_op(input logic [5:0] op, input logic [5:0] fn,
      input logic [4:0] sh, input logic [15:0] im, input logic [31:0] rs, input logic [31:0] rt,
      output bit legal, output logic [3:0] con, output logic [31:0] a, output logic [31:0] b,
      output int lat, output logic [31:0] res, output logic err);
    logic [31:0] sx, zx;
    sx = {{16{im[15]}}, im};
    zx = {16'h0, im};
    legal = 1; con = 0; a = rs; b = rt; lat = 2; res = 0; err = 0;
    if (op == 6'h00) begin
      case (fn)
        6'h24: begin con = 0; res = rs & rt; end
        6'h25: begin con = 1; res = rs | rt; end
        6'h20, 6'h21: begin con = 2; res = rs + rt; end
        6'h18: begin con = 3; res = rs * rt; lat = 1 + MUL_LAT; end
        6'h27: begin con = 4; res = ~(rs | rt); end
        6'h1A: begin
          con = 5;
          if (rt == 0) begin res = 32'hFFFF_FFFF; err = 1; lat = 1; end
          else begin res = 32'($signed(rs) / $signed(rt)); lat = 1 + DIV_LAT; end
        end
        6'h22, 6'h23: begin con = 6; res = rs - rt; end
        6'h2A: begin con = 7; res = ($signed(rs) < $signed(rt)) ? 1 : 0; end
        6'h00: begin con = 8; a = rt; b = {27'b0, sh}; res = rt << sh; end
        default: legal = 0;
      endcase
    end else begin
      case (op)
        6'h08, 6'h09, 6'h23, 6'h2B: begin con = 2; b = sx; res = rs + sx; end
        6'h0A: begin con = 7; b = sx; res = ($signed(rs) < $signed(sx)) ? 1 : 0; end
        6'h0C: begin con = 0; b = zx; res = rs & zx; end
        6'h0D: begin con = 1; b = zx; res = rs | zx; end
        default: legal = 0;
      endcase
    end
    if (!legal) begin res = 0; err = 1; lat = 1; end
  endfunction

  // Issues one instruction and follows it to out_valid; leaves the bench #1 after the edge
  // that drains the result (out_ready=1) or in Done (out_ready=0).
  task automatic do_op(input string name, input logic [5:0] op, input logic [5:0] fn,
      input logic [4:0] sh, input logic [15:0] im, input logic [31:0] rs, input logic [31:0] rt);
    bit legal, got;
    logic [3:0] con;
    logic [31:0] a, b, res;
    logic err;
    int lat, k;
    ref_op(op, fn, sh, im, rs, rt, legal, con, a, b, lat, res, err);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s ready_before_issue: in_ready=%b required 1", name, in_ready);
    end
    opcode = op; funct = fn; shamt = sh; imm = im; rs_data = rs; rt_data = rt;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (legal) begin m_con = con; m_a = a; m_b = b; end
    k = 1; got = 0;
    while (k <= 40) begin
      checks++;
      if (ALUCon !== m_con || DataA !== m_a || DataB !== m_b) begin
        failures++;
        $display("FAIL %s operands@T+%0d: got %h/%h/%h required %h/%h/%h", name, k,
                 ALUCon, DataA, DataB, m_con, m_a, m_b);
      end
      if (out_valid === 1'b1) begin got = 1; break; end
      checks++;
      if (in_ready !== 1'b0) begin
        failures++;
        $display("FAIL %s busy_ready@T+%0d: in_ready=%b required 0", name, k, in_ready);
      end
      @(posedge clk); #1;
      k++;
    end
    checks++;
    if (!got || k != lat) begin
      failures++;
      $display("FAIL %s latency: out_valid at T+%0d (seen=%0d) required T+%0d", name, k, got, lat);
    end
    checks++;
    if (out_result !== res || out_err !== err) begin
      failures++;
      $display("FAIL %s result: got %h err=%b required %h err=%b", name, out_result, out_err,
               res, err);
    end
`ifdef ALU_ISSUE_BACK2BACK_EN
    checks++;
    if (in_ready !== out_ready) begin
      failures++;
      $display("FAIL %s done_ready: in_ready=%b required %b", name, in_ready, out_ready);
    end
`else
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s done_ready: in_ready=%b required 0", name, in_ready);
    end
`endif
    if (out_ready) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL %s drain: out_valid=%b in_ready=%b required 0/1", name, out_valid,
                 in_ready);
      end
    end
  endtask

  task automatic check_idle_zero(input string name);
    checks++;
    if (ALUCon !== 4'd0 || DataA !== 32'd0 || DataB !== 32'd0 || out_result !== 32'd0 ||
        out_err !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s: con=%h a=%h b=%h res=%h err=%b ov=%b ir=%b required all zero, ir=1",
               name, ALUCon, DataA, DataB, out_result, out_err, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_idle_zero("reset_state");
    @(negedge clk);
    reset = 1'b0;
    m_con = 0; m_a = 0; m_b = 0;
  endtask

  task automatic test_add();
    do_op("add", 6'h00, 6'h20, 5'd0, 16'h0, 32'd5, 32'd7);
    do_op("sub", 6'h00, 6'h22, 5'd0, 16'h0, 32'd5, 32'd7);
    do_op("nor", 6'h00, 6'h27, 5'd0, 16'h0, 32'h0F0F_0000, 32'h0000_00FF);
  endtask

  task automatic test_immediates();
    do_op("addi", 6'h08, 6'h00, 5'd0, 16'hFFFF, 32'h10, 32'h0);
    do_op("andi", 6'h0C, 6'h00, 5'd0, 16'h8000, 32'hFFFF_FFFF, 32'h0);
    do_op("slti", 6'h0A, 6'h00, 5'd0, 16'hFFFE, 32'hFFFF_FFF0, 32'h0);
  endtask

  task automatic test_muldiv();
    do_op("mul", 6'h00, 6'h18, 5'd0, 16'h0, 32'd6, 32'd7);
    do_op("div", 6'h00, 6'h1A, 5'd0, 16'h0, 32'd100, 32'd7);
    do_op("div_zero", 6'h00, 6'h1A, 5'd0, 16'h0, 32'd100, 32'd0);
  endtask

  task automatic test_sll_illegal();
    do_op("sll", 6'h00, 6'h00, 5'd4, 16'h0, 32'h0, 32'h1);
    do_op("srl", 6'h00, 6'h02, 5'd4, 16'h0, 32'h0, 32'h1);
    do_op("beq", 6'h04, 6'h20, 5'd0, 16'h1, 32'h3, 32'h3);
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    do_op("bp_add", 6'h00, 6'h20, 5'd0, 16'h0, 32'd1, 32'd2);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_result !== 32'd3 || out_err !== 1'b0 || in_ready !== 1'b0)
      begin
        failures++;
        $display("FAIL bp_hold%0d: ov=%b res=%h err=%b ir=%b required 1/3/0/0", i, out_valid,
                 out_result, out_err, in_ready);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release: ov=%b ir=%b required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    opcode = 6'h00; funct = 6'h18; rs_data = 32'd6; rt_data = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check_idle_zero("reset_mid_mul");
    @(negedge clk);
    reset = 1'b0;
    m_con = 0; m_a = 0; m_b = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL reset_no_output%0d: out_valid=%b required 0", i, out_valid);
      end
    end
  endtask

  task automatic test_random();
    logic [5:0] op, fn;
    logic [31:0] rt;
    for (int n = 0; n < 40; n++) begin
      op = 6'h00;
      fn = 6'h20;
      case ($urandom_range(0, 17))
        0: fn = 6'h24;  1: fn = 6'h25;  2: fn = 6'h21;  3: fn = 6'h18;
        4: fn = 6'h27;  5: fn = 6'h1A;  6: fn = 6'h23;  7: fn = 6'h2A;
        8: fn = 6'h00;  9: fn = 6'h02;  10: fn = 6'h03;
        11: op = 6'h09; 12: op = 6'h0A; 13: op = 6'h0C;
        14: op = 6'h0D; 15: op = 6'h23; 16: op = 6'h2B;
        default: op = 6'h05;
      endcase
      rt = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      do_op("random", op, fn, 5'($urandom), 16'($urandom), $urandom, rt);
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    opcode = 0; funct = 0; shamt = 0; imm = 0; rs_data = 0; rt_data = 0;
    m_con = 0; m_a = 0; m_b = 0;
    test_reset();
    test_add();
    test_immediates();
    test_muldiv();
    test_sll_illegal();
    test_backpressure();
    test_reset_mid_op();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
